// File: rtl/bcd_pkg.sv
// Shared decimal-arithmetic definitions for the BCD datapath blocks.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
   localparam int         BCD_RADIX     = 10;

endpackage

// File: rtl/bcd_digit_sub.sv
// Single BCD digit subtract with borrow: d = a - b - bin, corrected by +10 on underflow.
module bcd_digit_sub
   import bcd_pkg::*;
(
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] d,
   output logic       bout
);

   logic signed [4:0] t;
   logic signed [4:0] tc;

   // Operands are 0..9, so t spans -10..9 and the corrected digit always lands in 0..9.
   always_comb begin
      t = $signed({1'b0, a}) - $signed({1'b0, b}) - $signed({4'b0000, bin});
      if (t < 0) begin
         tc   = t + $signed(5'(BCD_RADIX));
         bout = 1'b1;
      end else begin
         tc   = t;
         bout = 1'b0;
      end
      d = tc[3:0];
   end

endmodule

// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor (A - B), one digit per clock, valid/ready on both sides.
module bcd_subtractor_serial
   import bcd_pkg::*;
#(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   diff,
   output logic                  borrow,
   output logic                  err
);

   localparam int W     = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   state_t             state, state_nx;
   logic [W-1:0]       a_r, b_r, diff_r;
   logic               borrow_r, err_r, bi;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W+1:0]   bit_ofs;
   logic               in_err, last;
   logic [3:0]         d_cur;
   logic               bout;

   assign bit_ofs = {idx, 2'b00};
   assign last    = (idx == IDX_W'(DIGITS - 1));

   always_comb begin
      in_err = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] > BCD_MAX_DIGIT || b[4*i +: 4] > BCD_MAX_DIGIT)
            in_err = 1'b1;
      end
   end

   bcd_digit_sub u_dsub (
      .a    (a_r[bit_ofs +: 4]),
      .b    (b_r[bit_ofs +: 4]),
      .bin  (bi),
      .d    (d_cur),
      .bout (bout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // An invalid operand still spends one RUN cycle so the error path answers one edge after accept.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid) state_nx = RUN;
         RUN:     if (err_r || last) state_nx = DONE;
         DONE:    if (out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && in_valid) begin
         a_r <= a;
         b_r <= b;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         diff_r   <= '0;
         borrow_r <= 1'b0;
         err_r    <= 1'b0;
         idx      <= '0;
         bi       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  diff_r   <= '0;
                  borrow_r <= 1'b0;
                  err_r    <= in_err;
                  idx      <= '0;
                  bi       <= 1'b0;
               end
            end
            RUN: begin
               if (!err_r) begin
                  diff_r[bit_ofs +: 4] <= d_cur;
                  bi                   <= bout;
                  idx                  <= last ? '0 : idx + IDX_W'(1);
                  if (last) borrow_r <= bout;
               end
            end
            default: ;
         endcase
      end
   end

   assign diff   = diff_r;
   assign borrow = borrow_r;
   assign err    = err_r;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Scoreboard bench for bcd_subtractor_serial with DIGITS=4.
module tb_bcd_subtractor_serial;

   typedef struct packed {
      logic [15:0] diff;
      logic        borrow;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a, b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        borrow;
   logic        err;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   bcd_subtractor_serial #(.DIGITS(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .diff      (diff),
      .borrow    (borrow),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Reference: decode both operands to integers, subtract, re-encode modulo 10^4.
   function automatic exp_t model(input logic [15:0] ma, input logic [15:0] mb);
      exp_t e;
      int   av, bv, dv;
      logic bad;
      bad = 1'b0;
      av = 0;
      bv = 0;
      for (int i = 3; i >= 0; i--) begin
         if (ma[4*i +: 4] > 4'd9 || mb[4*i +: 4] > 4'd9) bad = 1'b1;
         av = av * 10 + int'(ma[4*i +: 4]);
         bv = bv * 10 + int'(mb[4*i +: 4]);
      end
      if (bad) begin
         e = '{diff: 16'h0000, borrow: 1'b0, err: 1'b1};
      end else begin
         dv = av - bv;
         e.borrow = (dv < 0);
         if (dv < 0) dv = dv + 10000;
         e.err = 1'b0;
         for (int i = 0; i < 4; i++) begin
            e.diff[4*i +: 4] = 4'(dv % 10);
            dv = dv / 10;
         end
      end
      return e;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present operands, wait for out_valid (bounded), then hand off with out_ready=1.
   task automatic do_txn(input logic [15:0] ta, input logic [15:0] tb_,
                         output int cycles, output exp_t got);
      a = ta;
      b = tb_;
      in_valid = 1'b1;
      out_ready = 1'b0;
      sb.push_back(model(ta, tb_));
      step();
      in_valid = 1'b0;
      cycles = 0;
      while (!out_valid && cycles < 20) begin
         step();
         cycles++;
      end
      got = '{diff: diff, borrow: borrow, err: err};
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      a = '0;
      b = '0;
      #1;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
      n_checks++; if ({diff, borrow, err} !== 18'h0) $display("FAIL reset_outputs got %h/%b/%b want 0000/0/0", diff, borrow, err); else n_pass++;
      step();
      step();
      rst = 1'b0;
      step();
      n_checks++; if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready); else n_pass++;
   endtask

   task automatic test_subtract();
      logic [15:0] va[5] = '{16'h0042, 16'h0017, 16'h0000, 16'h1000, 16'h5555};
      logic [15:0] vb[5] = '{16'h0017, 16'h0042, 16'h9999, 16'h0001, 16'h5555};
      int   cyc;
      exp_t got, exp;
      for (int i = 0; i < 5; i++) begin
         do_txn(va[i], vb[i], cyc, got);
         exp = sb.pop_front();
         n_checks++; if (cyc !== 4) $display("FAIL sub_latency[%0d] got %0d want 4", i, cyc); else n_pass++;
         n_checks++;
         if (got !== exp) $display("FAIL sub_result[%0d] got %h/%b/%b want %h/%b/%b", i, got.diff, got.borrow, got.err, exp.diff, exp.borrow, exp.err);
         else n_pass++;
         n_checks++; if (out_valid !== 1'b0) $display("FAIL sub_handoff[%0d] out_valid got %b want 0", i, out_valid); else n_pass++;
      end
   endtask

   task automatic test_error();
      int   cyc;
      exp_t got, exp;
      do_txn(16'h00A1, 16'h0003, cyc, got);
      exp = sb.pop_front();
      n_checks++; if (cyc !== 1) $display("FAIL err_latency got %0d want 1", cyc); else n_pass++;
      n_checks++;
      if (got !== exp) $display("FAIL err_result got %h/%b/%b want %h/%b/%b", got.diff, got.borrow, got.err, exp.diff, exp.borrow, exp.err);
      else n_pass++;
      do_txn(16'h0300, 16'h00F0, cyc, got);
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL err_b_result got %h/%b/%b want %h/%b/%b", got.diff, got.borrow, got.err, exp.diff, exp.borrow, exp.err);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int   cyc;
      exp_t exp;
      a = 16'h0300;
      b = 16'h0456;
      in_valid = 1'b1;
      out_ready = 1'b0;
      sb.push_back(model(a, b));
      step();
      cyc = 0;
      // Junk operands stay asserted through RUN and DONE; they must be ignored.
      a = 16'h9999;
      b = 16'h1111;
      while (!out_valid && cyc < 20) begin
         step();
         cyc++;
      end
      exp = sb.pop_front();
      n_checks++; if (cyc !== 4) $display("FAIL bp_latency got %0d want 4", cyc); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         step();
         n_checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== exp.diff || borrow !== exp.borrow || err !== exp.err)
            $display("FAIL bp_hold[%0d] got v=%b r=%b %h/%b/%b want v=1 r=0 %h/%b/%b", k, out_valid, in_ready, diff, borrow, err, exp.diff, exp.borrow, exp.err);
         else n_pass++;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL bp_release got v=%b r=%b want v=0 r=1", out_valid, in_ready); else n_pass++;
      step();
      n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_no_junk_accept in_ready got %b want 1", in_ready); else n_pass++;
   endtask

   task automatic test_rst_midrun();
      int   cyc;
      logic seen;
      exp_t got, exp;
      a = 16'h1234;
      b = 16'h0567;
      in_valid = 1'b1;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      rst = 1'b1;
      #1;
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL rst_midrun got v=%b r=%b want v=0 r=1", out_valid, in_ready); else n_pass++;
      step();
      rst = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      n_checks++; if (seen !== 1'b0) $display("FAIL rst_discard out_valid seen %b want 0", seen); else n_pass++;
      out_ready = 1'b0;
      do_txn(16'h5000, 16'h0001, cyc, got);
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) $display("FAIL rst_after_result got %h/%b/%b want %h/%b/%b", got.diff, got.borrow, got.err, exp.diff, exp.borrow, exp.err);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      int   cyc;
      exp_t exp;
      a = 16'h0800;
      b = 16'h0199;
      in_valid = 1'b1;
      out_ready = 1'b1;
      sb.push_back(model(a, b));
      step();
      a = 16'h0123;
      b = 16'h0456;
      sb.push_back(model(a, b));
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         step();
         cyc++;
      end
      exp = sb.pop_front();
      n_checks++;
      if (diff !== exp.diff || borrow !== exp.borrow || err !== exp.err)
         $display("FAIL b2b_first got %h/%b/%b want %h/%b/%b", diff, borrow, err, exp.diff, exp.borrow, exp.err);
      else n_pass++;
      step();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL b2b_gap got v=%b r=%b want v=0 r=1", out_valid, in_ready); else n_pass++;
      step();
      in_valid = 1'b0;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL b2b_second_accept in_ready got %b want 0", in_ready); else n_pass++;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         step();
         cyc++;
      end
      exp = sb.pop_front();
      n_checks++; if (cyc !== 4) $display("FAIL b2b_latency got %0d want 4", cyc); else n_pass++;
      n_checks++;
      if (diff !== exp.diff || borrow !== exp.borrow || err !== exp.err)
         $display("FAIL b2b_second got %h/%b/%b want %h/%b/%b", diff, borrow, err, exp.diff, exp.borrow, exp.err);
      else n_pass++;
      step();
      out_ready = 1'b0;
      n_checks++; if (sb.size() !== 0) $display("FAIL scoreboard_empty got %0d want 0", sb.size()); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_subtract();
      test_error();
      test_backpressure();
      test_rst_midrun();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
